// File: rtl/rr_mux.sv
// rr_mux: registered N-way channel selector with valid/ready on every port.
// Fixed-select or round-robin grant feeds a single output register.
module rr_mux #(
  parameter int  WIDTH    = 16,
  parameter int  CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SEL_W:0]   CH_N = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS-1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [2*CHANNELS-1:0] dbl;
  logic [CHANNELS-1:0]   rot;
  logic [SEL_W-1:0]      off;
  logic [SEL_W:0]        sum;
  logic [SEL_W-1:0]      rr_idx;
  logic                  rr_hit;
  logic                  fx_hit;
  logic                  grant_vld;
  logic [SEL_W-1:0]      grant_idx;
  logic [WIDTH-1:0]      grant_data;
  logic                  load_en;
  logic                  xfer;

  // Rotate valids so bit 0 is the channel at ptr, then take the lowest set bit.
  always_comb begin
    dbl    = {in_valid, in_valid} >> ptr_q;
    rot    = dbl[CHANNELS-1:0];
    rr_hit = |rot;
    off    = '0;
    for (int i = CHANNELS-1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= CH_N) sum = sum - CH_N;
    rr_idx = sum[SEL_W-1:0];
  end

  always_comb begin
    fx_hit = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k) && in_valid[k]) fx_hit = 1'b1;
    end
  end

  assign grant_vld = mode ? rr_hit : fx_hit;
  assign grant_idx = mode ? rr_idx : sel;
  assign load_en   = !out_valid_q || out_ready;
  assign xfer      = grant_vld && load_en && !reset;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        in_ready[k] = xfer;
        grant_data  = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = grant_data;
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      if (mode) begin
        ptr_d = (grant_idx == LAST) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux: scenario tasks plus random traffic against a
// behavioural arbiter model of rr_mux.
module tb_rr_mux;
  localparam int W  = 16;
  localparam int CH = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic            mode;
  logic [2:0]      sel;
  logic [W-1:0]    out_data;
  logic [2:0]      out_sel;
  logic            out_valid;
  logic            out_ready;

  logic [W-1:0] dat [CH];

  int n_chk  = 0;
  int n_fail = 0;

  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;

  always #5 clock = ~clock;

  always_comb begin
    in_data = '0;
    for (int k = 0; k < CH; k++) in_data[k*W +: W] = dat[k];
  end

  rr_mux #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic int model_grant();
    int k;
    if (!mode) return in_valid[sel] ? int'(sel) : -1;
    for (int i = 0; i < CH; i++) begin
      k = (m_ptr + i) % CH;
      if (in_valid[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [CH-1:0] exp_ready();
    logic [CH-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (!reset && g >= 0 && (!m_valid || out_ready)) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  task automatic model_edge();
    int g;
    g = model_grant();
    if (!reset && g >= 0 && (!m_valid || out_ready)) begin
      m_data  = dat[g];
      m_sel   = g;
      m_valid = 1'b1;
      if (mode) m_ptr = (g + 1) % CH;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < CH; k++) dat[k] = 16'(k);
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1; sel = 3'd0;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      n_chk += 4;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
      if (out_data !== 16'h0000) begin n_fail++; $display("FAIL rst_data got %h want 0000", out_data); end
      if (out_sel !== 3'd0) begin n_fail++; $display("FAIL rst_sel got %0d want 0", out_sel); end
      if (in_ready !== 8'h00) begin n_fail++; $display("FAIL rst_ready got %h want 00", in_ready); end
      @(posedge clock); #1;
    end
    reset = 1'b0;
    model_reset();
    out_ready = 1'b0;
    #2;
    n_chk++;
    if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rst_load_ready got %h want %h", in_ready, exp_ready()); end
    @(posedge clock); model_edge(); #1;
    n_chk++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_loaded got %b want 1", out_valid); end
    #3 reset = 1'b1;
    #1;
    n_chk += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got %b want 0", out_valid); end
    if (out_data !== 16'h0000) begin n_fail++; $display("FAIL async_rst_data got %h want 0000", out_data); end
    if (in_ready !== 8'h00) begin n_fail++; $display("FAIL async_rst_ready got %h want 00", in_ready); end
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_mode0_sweep();
    mode = 1'b0; in_valid = 8'hFF; out_ready = 1'b1;
    for (int s = 0; s < CH; s++) begin
      sel = 3'(s);
      #2;
      n_chk++;
      if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL m0_ready sel=%0d got %h want %h", s, in_ready, exp_ready()); end
      if (s == 3) begin
        n_chk++;
        if (in_ready !== 8'h08) begin n_fail++; $display("FAIL m0_ready_sel3 got %h want 08", in_ready); end
      end
      @(posedge clock); model_edge(); #1;
      n_chk += 3;
      if (out_data !== 16'(s)) begin n_fail++; $display("FAIL m0_data got %h want %h", out_data, 16'(s)); end
      if (int'(out_sel) !== s) begin n_fail++; $display("FAIL m0_sel got %0d want %0d", out_sel, s); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL m0_valid got %b want 1", out_valid); end
    end
  endtask

  task automatic test_rr_full();
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      n_chk++;
      if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rr_ready got %h want %h", in_ready, exp_ready()); end
      @(posedge clock); model_edge(); #1;
      n_chk += 3;
      if (int'(out_sel) !== i % CH) begin n_fail++; $display("FAIL rr_sel step %0d got %0d want %0d", i, out_sel, i % CH); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid got %b want 1", out_valid); end
      if (out_data !== m_data) begin n_fail++; $display("FAIL rr_data got %h want %h", out_data, m_data); end
    end
  endtask

  task automatic test_rr_sparse();
    logic [W-1:0] wd;
    int wp;
    mode = 1'b1; in_valid = 8'h24; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      n_chk++;
      if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL sp_ready got %h want %h", in_ready, exp_ready()); end
      @(posedge clock); model_edge(); #1;
      wd = (i % 2 == 0) ? 16'h0002 : 16'h0005;
      wp = (i % 2 == 0) ? 3 : 6;
      n_chk += 3;
      if (out_data !== wd) begin n_fail++; $display("FAIL sp_data got %h want %h", out_data, wd); end
      if (int'(dut.ptr_q) !== wp) begin n_fail++; $display("FAIL sp_ptr got %0d want %0d", dut.ptr_q, wp); end
      if (int'(dut.ptr_q) !== m_ptr) begin n_fail++; $display("FAIL sp_ptr_model got %0d want %0d", dut.ptr_q, m_ptr); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] hd;
    int hp, hs;
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    #2;
    @(posedge clock); model_edge(); #1;
    hd = m_data; hp = m_ptr; hs = m_sel;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_chk++;
      if (in_ready !== 8'h00) begin n_fail++; $display("FAIL bp_ready got %h want 00", in_ready); end
      @(posedge clock); model_edge(); #1;
      n_chk += 3;
      if (out_data !== hd) begin n_fail++; $display("FAIL bp_data got %h want %h", out_data, hd); end
      if (int'(dut.ptr_q) !== hp) begin n_fail++; $display("FAIL bp_ptr got %0d want %0d", dut.ptr_q, hp); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", out_valid); end
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #2;
      @(posedge clock); model_edge(); #1;
      n_chk += 2;
      if (int'(out_sel) !== (hs + i) % CH) begin n_fail++; $display("FAIL bp_resume got %0d want %0d", out_sel, (hs + i) % CH); end
      if (out_data !== m_data) begin n_fail++; $display("FAIL bp_resume_data got %h want %h", out_data, m_data); end
    end
  endtask

  task automatic test_no_grant();
    logic [W-1:0] hd;
    mode = 1'b0; sel = 3'd4; in_valid = 8'hEF; out_ready = 1'b1;
    hd = m_data;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_chk++;
      if (in_ready !== 8'h00) begin n_fail++; $display("FAIL ng_ready got %h want 00", in_ready); end
      @(posedge clock); model_edge(); #1;
      n_chk += 2;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ng_valid got %b want 0", out_valid); end
      if (out_data !== hd) begin n_fail++; $display("FAIL ng_hold got %h want %h", out_data, hd); end
    end
    sel = 3'd3;
    #2;
    n_chk++;
    if (in_ready !== 8'h08) begin n_fail++; $display("FAIL ng_sel3_ready got %h want 08", in_ready); end
    @(posedge clock); model_edge(); #1;
    n_chk += 3;
    if (out_data !== 16'h0003) begin n_fail++; $display("FAIL ng_sel3_data got %h want 0003", out_data); end
    if (out_sel !== 3'd3) begin n_fail++; $display("FAIL ng_sel3_sel got %0d want 3", out_sel); end
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ng_sel3_valid got %b want 1", out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < CH; k++) dat[k] = 16'($urandom);
      mode      = 1'($urandom);
      sel       = 3'($urandom);
      in_valid  = 8'($urandom) & 8'($urandom);
      out_ready = ($urandom_range(3) != 0);
      #2;
      n_chk++;
      if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %h want %h", i, in_ready, exp_ready()); end
      @(posedge clock); model_edge(); #1;
      n_chk += 4;
      if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, out_valid, m_valid); end
      if (out_data !== m_data) begin n_fail++; $display("FAIL rnd_data cyc %0d got %h want %h", i, out_data, m_data); end
      if (int'(out_sel) !== m_sel) begin n_fail++; $display("FAIL rnd_sel cyc %0d got %0d want %0d", i, out_sel, m_sel); end
      if (int'(dut.ptr_q) !== m_ptr) begin n_fail++; $display("FAIL rnd_ptr cyc %0d got %0d want %0d", i, dut.ptr_q, m_ptr); end
    end
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
    for (int k = 0; k < CH; k++) dat[k] = 16'(k);
    model_reset();
    @(posedge clock); #1;
    test_reset();
    test_mode0_sweep();
    test_rr_full();
    test_rr_sparse();
    test_backpressure();
    test_no_grant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
